// File: rtl/frame_playout_sequencer_if.sv
// Frame write / RAM / DAC handshake bundle for the playout sequencer.
// Slave side is the sequencer; master side is the feeder, RAM and DAC.
// Widths follow the frame length and sample word width.
interface frame_playout_sequencer_if #(
  parameter int FFT_SIZE = 1024,
  parameter int DATA_W   = 16
);
  localparam int AW = $clog2(FFT_SIZE);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_bank;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dac_data;
  logic              dac_strobe;
  logic              frame_done;
  logic              overrun;
  logic              underrun;

  modport slave (
    input  in_valid, in_data, rd_data,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data,
           rd_bank, rd_addr, dac_data, dac_strobe,
           frame_done, overrun, underrun
  );

  modport master (
    output in_valid, in_data, rd_data,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data,
           rd_bank, rd_addr, dac_data, dac_strobe,
           frame_done, overrun, underrun
  );
endinterface

// File: rtl/frame_playout_sequencer.sv
// Ping-pong frame buffer controller: bit-reversed writes in, natural-order playout.
// Latency: write accepted same cycle; sample reaches dac_data 2 cycles after its tick.
// Backpressure: in_ready low while the write bank is still full; offered words are dropped.
module frame_playout_sequencer #(
  parameter int FFT_SIZE   = 1024,
  parameter int SAMPLE_DIV = 64,
  parameter int DATA_W     = 16
) (
  input logic clk,
  input logic reset,
  frame_playout_sequencer_if.slave bus
);
  localparam int AW    = $clog2(FFT_SIZE);
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic {IDLE, PLAY} play_st_t;

  // Bank ownership and write side
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wbank_q;
  logic [AW-1:0]     wcount_q;
  logic              frame_done_q;
  logic              overrun_q;

  // Sample timing and read side
  logic [DIV_W-1:0]  div_cnt_q;
  play_st_t          st_q;
  logic              rbank_q;
  logic [AW-1:0]     rcount_q;
  logic              started_q;
  logic              underrun_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] dac_data_q;
  logic              dac_strobe_q;

  logic              in_ready;
  logic              wr_en;
  logic              wr_last;
  logic              rd_last;
  logic              tick;
  logic [AW-1:0]     wr_addr_rev;

  assign in_ready = ~bank_full_q[wbank_q];
  assign wr_en    = bus.in_valid & in_ready;
  assign wr_last  = wr_en & (wcount_q == AW'(FFT_SIZE - 1));
  assign tick     = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign rd_last  = (st_q == PLAY) & tick & (rcount_q == AW'(FFT_SIZE - 1));

  assign bus.in_ready   = in_ready;
  assign bus.wr_en      = wr_en;
  assign bus.wr_bank    = wbank_q;
  assign bus.wr_addr    = wr_addr_rev;
  assign bus.wr_data    = bus.in_data;
  assign bus.rd_bank    = rbank_q;
  assign bus.rd_addr    = rcount_q;
  assign bus.dac_data   = dac_data_q;
  assign bus.dac_strobe = dac_strobe_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.underrun   = underrun_q;

  // Incoming words arrive in bit-reversed order; reversing the count lands them naturally
  always_comb begin
    wr_addr_rev = '0;
    for (int i = 0; i < AW; i++) begin
      wr_addr_rev[i] = wcount_q[AW-1-i];
    end
  end

  // Writer sets and reader clears always target different banks, so both apply
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_last) bank_full_d[wbank_q] = 1'b1;
    if (rd_last) bank_full_d[rbank_q] = 1'b0;
  end

  // Write-side sequencing, bank fill flags and overrun capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full_q  <= '0;
      wbank_q      <= 1'b0;
      wcount_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bank_full_q  <= bank_full_d;
      frame_done_q <= wr_last;
      if (wr_en) begin
        if (wr_last) begin
          wcount_q <= '0;
          wbank_q  <= ~wbank_q;
        end else begin
          wcount_q <= wcount_q + AW'(1);
        end
      end
      if (bus.in_valid && !in_ready) overrun_q <= 1'b1;
    end
  end

  // Free-running output sample divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // Playout FSM: address sequencing, bank handover, DAC register and underrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= IDLE;
      rbank_q      <= 1'b0;
      rcount_q     <= '0;
      started_q    <= 1'b0;
      underrun_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      dac_data_q   <= '0;
      dac_strobe_q <= 1'b0;
    end else begin
      // RAM data for a tick's address is valid the following cycle
      rd_pend_q    <= 1'b0;
      dac_strobe_q <= rd_pend_q;
      if (rd_pend_q) dac_data_q <= bus.rd_data;
      case (st_q)
        IDLE: begin
          if (bank_full_q[rbank_q]) begin
            st_q      <= PLAY;
            rcount_q  <= '0;
            started_q <= 1'b1;
          end else if (tick && started_q) begin
            underrun_q <= 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            rd_pend_q <= 1'b1;
            if (rcount_q == AW'(FFT_SIZE - 1)) begin
              rcount_q <= '0;
              rbank_q  <= ~rbank_q;
              // Seamless handover when the other bank is already waiting
              if (!bank_full_q[~rbank_q]) st_q <= IDLE;
            end else begin
              rcount_q <= rcount_q + AW'(1);
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/frame_playout_sequencer.md
# frame_playout_sequencer

Ping-pong buffer controller between the envelope-modulation output and the DAC interface. It accepts bit-reversed-order frame words, writes them into one of two RAM banks at the natural-order address, and plays the completed bank out in sequential order at one word per output-sample period. It owns all RAM address/bank sequencing and the write/read bank handover, and flags overrun and underrun.

## Interface
Parameters:
- FFT_SIZE, 1024, words per frame; power of two; AW = $clog2(FFT_SIZE)
- SAMPLE_DIV, 64, clk cycles per output sample (≥ 4)
- DATA_W, 16, word width

Ports:
- clk  in  1  sole clock (the codebase's divided system clock)
- reset  in  1  asynchronous, active-high
- in_valid  in  1  frame word present (bit-reversed order; gaps allowed)
- in_data  in  DATA_W  frame word
- in_ready  out  1  current write bank is free
- wr_en  out  1  RAM write strobe
- wr_bank  out  1  bank being written
- wr_addr  out  AW  natural-order write address
- wr_data  out  DATA_W  write data
- rd_bank  out  1  bank being read
- rd_addr  out  AW  read address (registered)
- rd_data  in  DATA_W  RAM read data, valid 1 cycle after address sampled
- dac_data  out  DATA_W  registered sample to DAC interface
- dac_strobe  out  1  1-cycle pulse when dac_data updates
- frame_done  out  1  1-cycle pulse when a bank fills
- overrun  out  1  sticky: word offered while in_ready low
- underrun  out  1  sticky: sample tick with no data after first playback

## Operation
- State: bank_full[1:0], wbank, wcount[AW-1:0], rbank, rcount[AW-1:0], div_cnt, play state {IDLE, PLAY}, started flag.
- Write side, combinational: in_ready = !bank_full[wbank]; wr_en = in_valid & in_ready; wr_bank = wbank; wr_addr = bit-reverse(wcount) over AW bits; wr_data = in_data.
- On accepted word: wcount++. On accepting word with wcount == FFT_SIZE-1: bank_full[wbank] ← 1, wbank toggles, wcount ← 0, frame_done pulses next cycle.
- in_valid & !in_ready: word dropped, no write, overrun ← 1; wcount unchanged.
- Sample tick: div_cnt free-runs 0..SAMPLE_DIV-1 from reset; tick = (div_cnt == SAMPLE_DIV-1).
- IDLE: on any cycle with bank_full[rbank] = 1 → PLAY, rcount ← 0, started ← 1. On a tick while IDLE and started = 1: underrun ← 1, no strobe, dac_data holds.
- PLAY, on tick: RAM samples {rd_bank, rd_addr = rcount}; rcount++. If rcount == FFT_SIZE-1 on that tick: bank_full[rbank] ← 0, rbank toggles, rcount ← 0; stay PLAY if the other bank is full (seamless, next tick reads it), else → IDLE.
- rd_bank = rbank, rd_addr = rcount, both from registers, stable through the tick cycle.
- Simultaneous set (writer) and clear (reader) of bank_full hit different banks; both take effect. Writer never writes a full bank, so writer/reader never share a bank.
- Reset: all state and outputs 0 (in_ready = 1, dac_data = 0, flags 0, IDLE, div_cnt = 0). Reset mid-frame discards partial frame and any full banks.

## Timing
- Write: zero-latency accept; wr_en same cycle as in_valid & in_ready.
- frame_done: cycle after the last word is accepted; in_ready for the next bank is valid that same cycle.
- Playback: tick in cycle T; rd_data valid in T+1; dac_data registered at end of T+1; dac_strobe high in T+2 only.
- Bank release: bank_full clears at end of the tick cycle of its last address; writer may use it from T+1.
- First playback: IDLE→PLAY the cycle after bank_full sets; first read on the next tick (≤ SAMPLE_DIV cycles).
- Strobe period in steady PLAY: exactly SAMPLE_DIV cycles, including across bank switches.

## Test plan
- Reset: assert reset mid-cycle asynchronously -> all outputs 0, in_ready = 1 immediately; after release, first tick at cycle SAMPLE_DIV-1.
- Fill bank 0 with 1024 continuous words, in_data = k -> wr_addr sequence 0, 512, 256, 768, …, 1023; wr_bank = 0; frame_done one cycle after word 1023; wr_bank = 1 afterward.
- Playback order: in_data = bit-reverse(k) -> dac_data sequence 0, 1, 2, …, 1023, strobes exactly 64 cycles apart, strobe 2 cycles after each tick.
- Seamless switch: second frame filled before bank 0 finishes -> strobe spacing stays 64 across word 1023 → 0 of bank 1, rd_bank toggles, no underrun.
- Overrun: offer three frames back-to-back -> third frame sees in_ready = 0, wr_en never asserted, overrun = 1 sticky; in_ready returns once bank 0 is fully read.
- Underrun: one frame only -> after 1024 strobes, next tick gives no strobe, underrun = 1, dac_data holds 1023; reset clears underrun.
